read_ptr_fwft: RTL and testbench

//  Read-domain controller for the async FIFO; counterpart of the write-side pointer/full logic.

---
 rtl/read_ptr_fwft.sv | 143 ++++++++++++++
 tb/tb_read_ptr_fwft.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/read_ptr_fwft.sv
// Read-side controller of the async FIFO: Gray read pointer, registered empty/almost-empty/level,
// 1-cycle synchronous memory fetch, and a 2-entry first-word-fall-through output buffer.
module read_ptr_fwft #(
  parameter int unsigned ADDR_SIZE     = 4,
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned AEMPTY_THRESH = 2
) (
  input  logic                  i_rd_clk,
  input  logic                  i_rdrst_n,
  input  logic [ADDR_SIZE:0]    i_gray_q2_wrptr,
  output logic [ADDR_SIZE:0]    o_gray_rdptr,
  output logic [ADDR_SIZE-1:0]  o_rd_addr,
  output logic                  o_mem_rd_en,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_valid,
  input  logic                  i_rd_ready,
  output logic                  o_rd_empty,
  output logic                  o_rd_aempty,
  output logic [ADDR_SIZE:0]    o_rd_level
);

  localparam int unsigned PTR_W = ADDR_SIZE + 1;

  logic [PTR_W-1:0]      r_rd_bin;
  logic [PTR_W-1:0]      r_rd_gray;
  logic [PTR_W-1:0]      r_rd_level;
  logic                  r_rd_empty;
  logic                  r_rd_aempty;
  logic                  r_inflight;
  logic                  r_rd_valid;
  logic [1:0]            r_occ;
  logic [DATA_WIDTH-1:0] r_buf_head;
  logic [DATA_WIDTH-1:0] r_buf_tail;

  logic                  w_pop;
  logic                  w_fetch_en;
  logic [2:0]            w_pending;
  logic [PTR_W-1:0]      w_rd_bin_next;
  logic [PTR_W-1:0]      w_rd_gray_next;
  logic [PTR_W-1:0]      w_wr_bin;
  logic [PTR_W-1:0]      w_level_next;
  logic                  w_empty_next;
  logic                  w_aempty_next;
  logic [1:0]            w_occ_next;
  logic [DATA_WIDTH-1:0] w_head_next;
  logic [DATA_WIDTH-1:0] w_tail_next;

  // A fetch is only issued when the buffer has a free slot counting the word already in flight.
  assign w_pop          = r_rd_valid & i_rd_ready;
  assign w_pending      = 3'(r_occ) + 3'(r_inflight);
  assign w_fetch_en     = ~r_rd_empty & ((w_pending < 3'd2) | w_pop);
  assign w_rd_bin_next  = r_rd_bin + PTR_W'(w_fetch_en);
  assign w_rd_gray_next = (w_rd_bin_next >> 1) ^ w_rd_bin_next;

  // Gray-to-binary conversion of the synchronized write pointer.
  always_comb begin
    w_wr_bin            = '0;
    w_wr_bin[PTR_W-1]   = i_gray_q2_wrptr[PTR_W-1];
    for (int i = int'(PTR_W) - 2; i >= 0; i--) begin
      w_wr_bin[i] = w_wr_bin[i+1] ^ i_gray_q2_wrptr[i];
    end
  end

  assign w_level_next  = w_wr_bin - w_rd_bin_next;
  assign w_empty_next  = (w_rd_gray_next == i_gray_q2_wrptr);
  assign w_aempty_next = (w_level_next <= PTR_W'(AEMPTY_THRESH));

  // Output buffer next state: head is slot 0, tail is slot 1; strict FIFO order.
  always_comb begin
    w_head_next = r_buf_head;
    w_tail_next = r_buf_tail;
    w_occ_next  = r_occ;
    case ({r_inflight, w_pop})
      2'b01: begin
        w_head_next = r_buf_tail;
        w_occ_next  = r_occ - 2'd1;
      end
      2'b10: begin
        if (r_occ == 2'd0) begin
          w_head_next = i_mem_rdata;
        end else begin
          w_tail_next = i_mem_rdata;
        end
        w_occ_next = r_occ + 2'd1;
      end
      2'b11: begin
        if (r_occ == 2'd1) begin
          w_head_next = i_mem_rdata;
        end else begin
          w_head_next = r_buf_tail;
          w_tail_next = i_mem_rdata;
        end
      end
      default: begin
      end
    endcase
  end

  // Pointer and status flags.
  always_ff @(posedge i_rd_clk or negedge i_rdrst_n) begin
    if (!i_rdrst_n) begin
      r_rd_bin    <= '0;
      r_rd_gray   <= '0;
      r_rd_empty  <= 1'b1;
      r_rd_aempty <= 1'b1;
      r_rd_level  <= '0;
    end else begin
      r_rd_bin    <= w_rd_bin_next;
      r_rd_gray   <= w_rd_gray_next;
      r_rd_empty  <= w_empty_next;
      r_rd_aempty <= w_aempty_next;
      r_rd_level  <= w_level_next;
    end
  end

  // In-flight flag and output buffer.
  always_ff @(posedge i_rd_clk or negedge i_rdrst_n) begin
    if (!i_rdrst_n) begin
      r_inflight <= 1'b0;
      r_occ      <= 2'd0;
      r_rd_valid <= 1'b0;
      r_buf_head <= '0;
      r_buf_tail <= '0;
    end else begin
      r_inflight <= w_fetch_en;
      r_occ      <= w_occ_next;
      r_rd_valid <= (w_occ_next != 2'd0);
      r_buf_head <= w_head_next;
      r_buf_tail <= w_tail_next;
    end
  end

  assign o_gray_rdptr = r_rd_gray;
  assign o_rd_addr    = r_rd_bin[ADDR_SIZE-1:0];
  assign o_mem_rd_en  = w_fetch_en;
  assign o_rd_data    = r_buf_head;
  assign o_rd_valid   = r_rd_valid;
  assign o_rd_empty   = r_rd_empty;
  assign o_rd_aempty  = r_rd_aempty;
  assign o_rd_level   = r_rd_level;

endmodule

// File: tb/tb_read_ptr_fwft.sv
// Bench for read_ptr_fwft: behavioural memory + write pointer driver, scoreboard of written words
// compared on every accepted output beat, plus per-cycle pointer/level/flag model.
module tb_read_ptr_fwft;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned PW = AW + 1;
  localparam int unsigned TH = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [PW-1:0] q2_wrptr;
  logic [PW-1:0] gray_rdptr;
  logic [AW-1:0] rd_addr;
  logic          mem_rd_en;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_ready;
  logic          rd_empty;
  logic          rd_aempty;
  logic [PW-1:0] rd_level;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] exp_q [$];
  logic [PW-1:0] wr_bin;
  logic [PW-1:0] wr_seen;
  logic [PW-1:0] rd_model;
  logic [PW-1:0] prev_gray;
  bit            wrap_seen;
  int            pops;
  int            checks;
  int            errors;

  always #5 clk = ~clk;

  read_ptr_fwft #(.ADDR_SIZE(AW), .DATA_WIDTH(DW), .AEMPTY_THRESH(TH)) dut (
    .i_rd_clk        (clk),
    .i_rdrst_n       (rst_n),
    .i_gray_q2_wrptr (q2_wrptr),
    .o_gray_rdptr    (gray_rdptr),
    .o_rd_addr       (rd_addr),
    .o_mem_rd_en     (mem_rd_en),
    .i_mem_rdata     (mem_rdata),
    .o_rd_data       (rd_data),
    .o_rd_valid      (rd_valid),
    .i_rd_ready      (rd_ready),
    .o_rd_empty      (rd_empty),
    .o_rd_aempty     (rd_aempty),
    .o_rd_level      (rd_level)
  );

  // Dual-port memory read side: one-cycle synchronous read.
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[rd_addr];

  function automatic logic [PW-1:0] to_gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic int space_left();
    logic [PW-1:0] used;
    used = wr_bin - rd_model;
    return (1 << AW) - int'(used);
  endfunction

  // Write n words into memory, queue them as expected output, advance the write pointer.
  task automatic push(input int n);
    logic [DW-1:0] d;
    for (int k = 0; k < n; k++) begin
      d = DW'($urandom);
      mem[wr_bin[AW-1:0]] = d;
      exp_q.push_back(d);
      wr_bin = wr_bin + PW'(1);
    end
    q2_wrptr = to_gray(wr_bin);
  endtask

  // One clock: mid-cycle scoreboard and pointer-model checks, then advance the model at the edge.
  task automatic tick();
    logic          fetch;
    logic [PW-1:0] lvl;
    logic [DW-1:0] exp_d;
    @(negedge clk);
    if (rd_valid && rd_ready) begin
      checks++;
      pops++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_extra got %h want no beat", rd_data);
      end else begin
        exp_d = exp_q.pop_front();
        if (rd_data !== exp_d) begin
          errors++;
          $display("FAIL pop_data got %h want %h", rd_data, exp_d);
        end
      end
    end
    lvl = wr_seen - rd_model;
    checks++;
    if (gray_rdptr !== to_gray(rd_model)) begin
      errors++;
      $display("FAIL gray_ptr got %b want %b", gray_rdptr, to_gray(rd_model));
    end
    checks++;
    if (rd_level !== lvl) begin
      errors++;
      $display("FAIL level got %0d want %0d", rd_level, lvl);
    end
    checks++;
    if (rd_empty !== (lvl == 0)) begin
      errors++;
      $display("FAIL empty got %b want %b", rd_empty, (lvl == 0));
    end
    checks++;
    if (rd_aempty !== (lvl <= TH)) begin
      errors++;
      $display("FAIL aempty got %b want %b (level %0d)", rd_aempty, (lvl <= TH), lvl);
    end
    checks++;
    if ($countones(gray_rdptr ^ prev_gray) > 1) begin
      errors++;
      $display("FAIL gray_step got %b prev %b want <=1 bit change", gray_rdptr, prev_gray);
    end
    if (mem_rd_en) begin
      checks++;
      if (rd_empty || rd_addr !== rd_model[AW-1:0]) begin
        errors++;
        $display("FAIL fetch got addr %0d empty %b want addr %0d empty 0", rd_addr, rd_empty, rd_model[AW-1:0]);
      end
    end
    fetch     = mem_rd_en;
    prev_gray = gray_rdptr;
    @(posedge clk);
    if (fetch) begin
      rd_model = rd_model + PW'(1);
      if (rd_model == '0) wrap_seen = 1'b1;
    end
    wr_seen = wr_bin;
    #1;
  endtask

  task automatic drain(input int budget, input string tag);
    int c;
    rd_ready = 1'b1;
    c = 0;
    while ((exp_q.size() != 0 || rd_valid) && c < budget) begin
      tick();
      c++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain got %0d words left want 0", tag, exp_q.size());
    end
  endtask

  task automatic reset_model();
    wr_bin    = '0;
    wr_seen   = '0;
    rd_model  = '0;
    prev_gray = '0;
    q2_wrptr  = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (gray_rdptr !== '0 || rd_valid !== 1'b0 || rd_data !== '0 ||
        rd_empty !== 1'b1 || rd_aempty !== 1'b1 || rd_level !== '0) begin
      errors++;
      $display("FAIL %s got gray %b valid %b data %h empty %b aempty %b level %0d want 0 0 0 1 1 0",
               tag, gray_rdptr, rd_valid, rd_data, rd_empty, rd_aempty, rd_level);
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    rd_ready = 1'b0;
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset_init");
    checks++;
    if (mem_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_rd_en got %b want 0", mem_rd_en);
    end
    rst_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_single();
    logic [5:0] e_empty;
    logic [5:0] e_en;
    logic [5:0] e_valid;
    e_empty  = 6'b111101;
    e_en     = 6'b000010;
    e_valid  = 6'b001000;
    rd_ready = 1'b1;
    push(1);
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (rd_empty !== e_empty[c] || mem_rd_en !== e_en[c] || rd_valid !== e_valid[c]) begin
        errors++;
        $display("FAIL single_c%0d got empty %b en %b valid %b want %b %b %b",
                 c, rd_empty, mem_rd_en, rd_valid, e_empty[c], e_en[c], e_valid[c]);
      end
      if (c == 1) begin
        checks++;
        if (rd_addr !== 4'd0) begin
          errors++;
          $display("FAIL single_addr got %0d want 0", rd_addr);
        end
      end
      tick();
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL single_delivered got %0d left want 0", exp_q.size());
    end
  endtask

  task automatic test_stream();
    int en_cnt, valid_cnt, first_en, last_en, c;
    en_cnt = 0; valid_cnt = 0; first_en = -1; last_en = -1;
    rd_ready = 1'b1;
    push(16);
    c = 0;
    while ((exp_q.size() != 0 || rd_valid) && c < 60) begin
      if (mem_rd_en) begin
        en_cnt++;
        if (first_en < 0) first_en = c;
        last_en = c;
      end
      if (rd_valid) valid_cnt++;
      tick();
      c++;
    end
    checks++;
    if (en_cnt != 16 || last_en - first_en + 1 != 16) begin
      errors++;
      $display("FAIL stream_fetch got %0d fetches span %0d want 16 16", en_cnt, last_en - first_en + 1);
    end
    checks++;
    if (valid_cnt != 16) begin
      errors++;
      $display("FAIL stream_valid got %0d cycles want 16", valid_cnt);
    end
    checks++;
    if (exp_q.size() != 0 || rd_empty !== 1'b1) begin
      errors++;
      $display("FAIL stream_end got %0d left empty %b want 0 1", exp_q.size(), rd_empty);
    end
  endtask

  task automatic test_backpressure();
    int fetches, pops0;
    logic [DW-1:0] d0;
    d0 = '0;
    fetches = 0;
    rd_ready = 1'b0;
    push(16);
    for (int c = 0; c < 10; c++) begin
      if (mem_rd_en) fetches++;
      if (c == 4) d0 = rd_data;
      tick();
    end
    checks++;
    if (fetches != 2) begin
      errors++;
      $display("FAIL bp_fetches got %0d want 2", fetches);
    end
    checks++;
    if (rd_level !== PW'(14)) begin
      errors++;
      $display("FAIL bp_level got %0d want 14", rd_level);
    end
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== d0 || rd_data !== exp_q[0]) begin
      errors++;
      $display("FAIL bp_hold got valid %b data %h want 1 %h", rd_valid, rd_data, exp_q[0]);
    end
    pops0 = pops;
    drain(80, "bp");
    checks++;
    if (pops - pops0 != 16) begin
      errors++;
      $display("FAIL bp_count got %0d beats want 16", pops - pops0);
    end
  endtask

  task automatic test_wrap();
    int sent, n, c;
    sent = 0;
    c = 0;
    wrap_seen = 1'b0;
    while ((sent < 40 || exp_q.size() != 0 || rd_valid) && c < 1500) begin
      rd_ready = ($urandom_range(0, 3) != 0);
      if (sent < 40 && $urandom_range(0, 2) == 0) begin
        n = int'($urandom_range(1, 6));
        if (n > 40 - sent) n = 40 - sent;
        if (n > space_left()) n = space_left();
        push(n);
        sent += n;
      end
      tick();
      c++;
    end
    checks++;
    if (sent != 40 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL wrap_done got sent %0d left %0d want 40 0", sent, exp_q.size());
    end
    checks++;
    if (!wrap_seen) begin
      errors++;
      $display("FAIL wrap_seen got 0 want 1");
    end
  endtask

  task automatic test_threshold();
    logic [4:0] e_aempty;
    e_aempty = 5'b11100;
    rd_ready = 1'b0;
    push(6);
    repeat (6) tick();
    rd_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (rd_level !== PW'(4 - c) || rd_aempty !== e_aempty[c]) begin
        errors++;
        $display("FAIL thresh_c%0d got level %0d aempty %b want %0d %b",
                 c, rd_level, rd_aempty, 4 - c, e_aempty[c]);
      end
      tick();
    end
    drain(40, "thresh");
  endtask

  task automatic test_reset_mid();
    rd_ready = 1'b1;
    push(10);
    repeat (5) tick();
    checks++;
    if (rd_valid !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre got valid %b want 1", rd_valid);
    end
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_model();
    rst_n = 1'b1;
    repeat (4) tick();
    checks++;
    if (rd_valid !== 1'b0 || rd_empty !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_post got valid %b empty %b want 0 1", rd_valid, rd_empty);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    pops   = 0;
    wrap_seen = 1'b0;
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_wrap();
    test_threshold();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
